// File: rtl/us_arp_tx.sv
// us_arp_tx: ARP request/reply frame generator feeding the MAC TX arbiter.
// A whole 60-byte frame is built into a register at capture time and then
// streamed as 8 x 64-bit AXI-Stream beats (last beat carries 4 bytes).
module us_arp_tx #(
    parameter int DROP_CNT_W = 16
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic [47:0]           local_mac_addr,
    input  logic [31:0]           local_ip_addr,
    input  logic [31:0]           dst_ip_addr,
    input  logic                  arp_request_req,
    output logic                  arp_request_ack,
    input  logic                  reply_req,
    input  logic [47:0]           reply_mac_addr,
    input  logic [31:0]           reply_ip_addr,
    output logic [63:0]           m_axis_tdata,
    output logic [7:0]            m_axis_tkeep,
    output logic                  m_axis_tvalid,
    output logic                  m_axis_tlast,
    input  logic                  m_axis_tready,
    output logic [DROP_CNT_W-1:0] reply_drop_cnt
);

    typedef enum logic {IDLE = 1'b0, SEND = 1'b1} state_t;

    state_t         state, state_nxt;
    logic [479:0]   frame;
    logic [511:0]   frame_ext;
    logic [2:0]     beat;
    logic           cap_reply, cap_req;

    logic           pend_vld;
    logic [47:0]    pend_mac;
    logic [31:0]    pend_ip;
    logic           drop;

    // Byte n of the frame lives in bits [8n+7:8n]; multi-byte fields are
    // written MSB first so they come out big-endian on the wire.
    function automatic logic [479:0] build_frame(
        input logic        is_reply,
        input logic [47:0] smac,
        input logic [31:0] sip,
        input logic [47:0] tmac,
        input logic [31:0] tip
    );
        logic [479:0] f;
        logic [47:0]  da;
        logic [47:0]  tha;
        logic [15:0]  oper;
        f    = '0;
        da   = is_reply ? tmac : 48'hFFFF_FFFF_FFFF;
        tha  = is_reply ? tmac : 48'h0;
        oper = is_reply ? 16'd2 : 16'd1;
        for (int i = 0; i < 6; i++) begin
            f[8*i      +: 8] = da[8*(5-i)   +: 8];
            f[8*(6+i)  +: 8] = smac[8*(5-i) +: 8];
            f[8*(22+i) +: 8] = smac[8*(5-i) +: 8];
            f[8*(32+i) +: 8] = tha[8*(5-i)  +: 8];
        end
        for (int i = 0; i < 4; i++) begin
            f[8*(28+i) +: 8] = sip[8*(3-i) +: 8];
            f[8*(38+i) +: 8] = tip[8*(3-i) +: 8];
        end
        f[8*12 +: 8] = 8'h08;
        f[8*13 +: 8] = 8'h06;
        f[8*14 +: 8] = 8'h00;
        f[8*15 +: 8] = 8'h01;
        f[8*16 +: 8] = 8'h08;
        f[8*17 +: 8] = 8'h00;
        f[8*18 +: 8] = 8'h06;
        f[8*19 +: 8] = 8'h04;
        f[8*20 +: 8] = oper[15:8];
        f[8*21 +: 8] = oper[7:0];
        return f;
    endfunction

    // Beat 7 reads past the 60-byte frame; the upper 4 bytes read as zero.
    assign frame_ext = {32'h0, frame};

    // A reply is dropped only if the entry stays occupied this cycle.
    assign drop = reply_req && pend_vld && !cap_reply;

    // Next-state, capture decisions and AXI-Stream outputs.
    always_comb begin
        state_nxt     = state;
        cap_reply     = 1'b0;
        cap_req       = 1'b0;
        m_axis_tvalid = 1'b0;
        m_axis_tlast  = 1'b0;
        m_axis_tkeep  = 8'h00;
        m_axis_tdata  = 64'h0;
        case (state)
            IDLE: begin
                if (pend_vld) begin
                    cap_reply = 1'b1;
                    state_nxt = SEND;
                end else if (arp_request_req) begin
                    cap_req   = 1'b1;
                    state_nxt = SEND;
                end
            end
            SEND: begin
                m_axis_tvalid = 1'b1;
                m_axis_tdata  = frame_ext[{beat, 6'b0} +: 64];
                m_axis_tkeep  = (beat == 3'd7) ? 8'h0F : 8'hFF;
                m_axis_tlast  = (beat == 3'd7);
                if (m_axis_tready && beat == 3'd7)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rstn) state <= IDLE;
        else       state <= state_nxt;
    end

    // Frame capture and beat counter; frame contents need no reset since
    // outputs are gated by state.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            beat <= 3'd0;
        end else if (cap_reply || cap_req) begin
            beat <= 3'd0;
        end else if (state == SEND && m_axis_tready) begin
            beat <= beat + 3'd1;
        end
    end

    // Frame register loaded from the current inputs or the pending entry.
    always_ff @(posedge clk) begin
        if (cap_reply)
            frame <= build_frame(1'b1, local_mac_addr, local_ip_addr, pend_mac, pend_ip);
        else if (cap_req)
            frame <= build_frame(1'b0, local_mac_addr, local_ip_addr, 48'h0, dst_ip_addr);
    end

    // Ack pulses the cycle after a request is captured.
    always_ff @(posedge clk) begin
        if (!rstn) arp_request_ack <= 1'b0;
        else       arp_request_ack <= cap_req;
    end

    // Single-entry pending reply; a new reply may refill the slot in the
    // same cycle the old one is captured.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            pend_vld <= 1'b0;
        end else if (reply_req && !drop) begin
            pend_vld <= 1'b1;
        end else if (cap_reply) begin
            pend_vld <= 1'b0;
        end
    end

    // Pending payload, only written when the slot accepts the reply.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            pend_mac <= 48'h0;
            pend_ip  <= 32'h0;
        end else if (reply_req && !drop) begin
            pend_mac <= reply_mac_addr;
            pend_ip  <= reply_ip_addr;
        end
    end

    // Saturating dropped-reply counter.
    always_ff @(posedge clk) begin
        if (!rstn)
            reply_drop_cnt <= '0;
        else if (drop && reply_drop_cnt != {DROP_CNT_W{1'b1}})
            reply_drop_cnt <= reply_drop_cnt + DROP_CNT_W'(1);
    end

endmodule

// File: tb/tb_us_arp_tx.sv
// tb_us_arp_tx: scoreboard bench for the ARP frame generator.
module tb_us_arp_tx;

    localparam int DW = 3;

    logic          clk;
    logic          rstn;
    logic [47:0]   local_mac_addr;
    logic [31:0]   local_ip_addr;
    logic [31:0]   dst_ip_addr;
    logic          arp_request_req;
    logic          arp_request_ack;
    logic          reply_req;
    logic [47:0]   reply_mac_addr;
    logic [31:0]   reply_ip_addr;
    logic [63:0]   m_axis_tdata;
    logic [7:0]    m_axis_tkeep;
    logic          m_axis_tvalid;
    logic          m_axis_tlast;
    logic          m_axis_tready;
    logic [DW-1:0] reply_drop_cnt;

    us_arp_tx #(.DROP_CNT_W(DW)) dut (
        .clk             (clk),
        .rstn            (rstn),
        .local_mac_addr  (local_mac_addr),
        .local_ip_addr   (local_ip_addr),
        .dst_ip_addr     (dst_ip_addr),
        .arp_request_req (arp_request_req),
        .arp_request_ack (arp_request_ack),
        .reply_req       (reply_req),
        .reply_mac_addr  (reply_mac_addr),
        .reply_ip_addr   (reply_ip_addr),
        .m_axis_tdata    (m_axis_tdata),
        .m_axis_tkeep    (m_axis_tkeep),
        .m_axis_tvalid   (m_axis_tvalid),
        .m_axis_tlast    (m_axis_tlast),
        .m_axis_tready   (m_axis_tready),
        .reply_drop_cnt  (reply_drop_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] d;
        logic [7:0]  k;
        logic        l;
    } beat_t;

    beat_t       exp_q[$];
    logic [7:0]  mb[$];
    logic [63:0] frame_log[8];
    logic [63:0] req_log[8];
    int          n_tests = 0;
    int          n_fail  = 0;
    int          n_frames = 0;
    int          n_acks   = 0;
    int          bidx     = 0;
    int          rdy_mode = 0;
    int          exp_drop = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic put(input logic [47:0] v, input int n);
        for (int i = n - 1; i >= 0; i--) mb.push_back(v[8*i +: 8]);
    endtask

    // Reference frame: list the wire bytes in order, pad to 64, slice to beats.
    task automatic push_frame(input logic is_reply, input logic [47:0] lmac,
                              input logic [31:0] lip, input logic [47:0] tmac,
                              input logic [31:0] tip);
        beat_t e;
        mb.delete();
        put(is_reply ? tmac : 48'hFFFF_FFFF_FFFF, 6);
        put(lmac, 6);
        put(48'h0806, 2);
        put(48'h0001, 2);
        put(48'h0800, 2);
        put(48'h06, 1);
        put(48'h04, 1);
        put(is_reply ? 48'd2 : 48'd1, 2);
        put(lmac, 6);
        put({16'h0, lip}, 4);
        put(is_reply ? tmac : 48'h0, 6);
        put({16'h0, tip}, 4);
        while (mb.size() < 64) mb.push_back(8'h00);
        for (int j = 0; j < 8; j++) begin
            e.d = 64'h0;
            for (int k = 0; k < 8; k++) e.d[8*k +: 8] = mb[8*j + k];
            e.k = (j == 7) ? 8'h0F : 8'hFF;
            e.l = (j == 7);
            exp_q.push_back(e);
        end
    endtask

    // tready pattern: full rate, random, or held low.
    always @(posedge clk) begin
        #1;
        case (rdy_mode)
            0:       m_axis_tready = 1'b1;
            1:       m_axis_tready = 1'($urandom_range(0, 1));
            default: m_axis_tready = 1'b0;
        endcase
    end

    // Output monitor: scoreboard pop on handshake, stall stability, gap.
    logic        stall_prev = 1'b0;
    logic        last_prev  = 1'b0;
    logic [63:0] sd;
    logic [7:0]  sk;
    logic        sl;
    always @(negedge clk) begin
        beat_t e;
        if (!rstn) begin
            stall_prev = 1'b0;
            last_prev  = 1'b0;
            bidx       = 0;
        end else begin
            if (stall_prev) begin
                chk("stall_tdata", m_axis_tdata, sd);
                chk("stall_tkeep", {56'h0, m_axis_tkeep}, {56'h0, sk});
                chk("stall_tlast", {63'h0, m_axis_tlast}, {63'h0, sl});
            end
            if (last_prev) chk("gap_tvalid", {63'h0, m_axis_tvalid}, 64'h0);
            last_prev = 1'b0;
            if (m_axis_tvalid && m_axis_tready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_beat", {63'h0, m_axis_tvalid}, 64'h0);
                end else begin
                    e = exp_q.pop_front();
                    chk("tdata", m_axis_tdata, e.d);
                    chk("tkeep", {56'h0, m_axis_tkeep}, {56'h0, e.k});
                    chk("tlast", {63'h0, m_axis_tlast}, {63'h0, e.l});
                end
                frame_log[bidx % 8] = m_axis_tdata;
                if (m_axis_tlast) begin
                    bidx = 0;
                    n_frames++;
                    last_prev = 1'b1;
                end else begin
                    bidx++;
                end
            end
            stall_prev = m_axis_tvalid && !m_axis_tready;
            sd = m_axis_tdata;
            sk = m_axis_tkeep;
            sl = m_axis_tlast;
            if (arp_request_ack) n_acks++;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_ack(input int budget, output int lat);
        lat = 0;
        while (!arp_request_ack && lat < budget) begin
            tick(1);
            lat++;
        end
        chk("ack_seen", {63'h0, arp_request_ack}, 64'h1);
    endtask

    task automatic drain(input int budget);
        int c;
        c = 0;
        while ((exp_q.size() != 0 || m_axis_tvalid) && c < budget) begin
            tick(1);
            c++;
        end
        chk("drain_empty", 64'(exp_q.size()), 64'h0);
    endtask

    task automatic reply_pulse(input logic [47:0] mac, input logic [31:0] ip);
        reply_req      = 1'b1;
        reply_mac_addr = mac;
        reply_ip_addr  = ip;
        tick(1);
        reply_req      = 1'b0;
    endtask

    task automatic set_req_inputs();
        local_mac_addr = 48'h000A_3501_0203;
        local_ip_addr  = 32'hC0A8_010A;
        dst_ip_addr    = 32'hC0A8_0114;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int f0, a0;
        rstn = 1'b0;
        arp_request_req = 1'b0;
        reply_req = 1'b0;
        reply_mac_addr = 48'h0;
        reply_ip_addr = 32'h0;
        m_axis_tready = 1'b0;
        set_req_inputs();
        tick(3);

        // Reset state.
        chk("rst_tvalid", {63'h0, m_axis_tvalid}, 64'h0);
        chk("rst_tlast", {63'h0, m_axis_tlast}, 64'h0);
        chk("rst_tkeep", {56'h0, m_axis_tkeep}, 64'h0);
        chk("rst_tdata", m_axis_tdata, 64'h0);
        chk("rst_ack", {63'h0, arp_request_ack}, 64'h0);
        chk("rst_drop", {61'h0, reply_drop_cnt}, 64'h0);
        rstn = 1'b1;
        tick(2);

        // Request frame at full rate; inputs change right after capture.
        push_frame(1'b0, 48'h000A_3501_0203, 32'hC0A8_010A, 48'h0, 32'hC0A8_0114);
        arp_request_req = 1'b1;
        wait_ack(10, lat);
        chk("req_ack_latency", 64'(lat), 64'd1);
        arp_request_req = 1'b0;
        local_mac_addr  = 48'hDEAD_BEEF_0000;
        dst_ip_addr     = 32'h0;
        drain(40);
        tick(2);
        chk("req_frames", 64'(n_frames), 64'd1);
        chk("req_acks", 64'(n_acks), 64'd1);
        chk("req_beat0", frame_log[0], 64'h0A00_FFFF_FFFF_FFFF);
        chk("req_beat1", frame_log[1], 64'h0100_0608_0302_0135);
        chk("req_oper", {48'h0, frame_log[2][47:32]}, 64'h0100);
        chk("req_tpa_hi", {48'h0, frame_log[4][63:48]}, 64'hA8C0);
        chk("req_tpa_lo", {48'h0, frame_log[5][15:0]}, 64'h1401);
        for (int i = 0; i < 8; i++) req_log[i] = frame_log[i];

        // Reply frame: two-cycle latency, no ack.
        local_mac_addr = 48'h1122_0A0B_0C0D;
        a0 = n_acks;
        push_frame(1'b1, 48'h1122_0A0B_0C0D, 32'hC0A8_010A, 48'h1122_3344_5566, 32'hC0A8_0105);
        reply_pulse(48'h1122_3344_5566, 32'hC0A8_0105);
        chk("rep_lat_n1", {63'h0, m_axis_tvalid}, 64'h0);
        tick(1);
        chk("rep_lat_n2", {63'h0, m_axis_tvalid}, 64'h1);
        drain(40);
        tick(2);
        chk("rep_no_ack", 64'(n_acks - a0), 64'd0);
        chk("rep_beat0", frame_log[0], 64'h2211_6655_4433_2211);
        chk("rep_oper", {48'h0, frame_log[2][47:32]}, 64'h0200);
        chk("rep_tha", {16'h0, frame_log[4][47:0]}, 64'h6655_4433_2211);

        // Backpressure: same content as the full-rate request.
        set_req_inputs();
        rdy_mode = 1;
        push_frame(1'b0, 48'h000A_3501_0203, 32'hC0A8_010A, 48'h0, 32'hC0A8_0114);
        arp_request_req = 1'b1;
        wait_ack(10, lat);
        arp_request_req = 1'b0;
        drain(300);
        rdy_mode = 0;
        tick(2);
        for (int i = 0; i < 8; i++) chk("bp_same_beat", frame_log[i], req_log[i]);

        // Priority and drop: reply A beats a held request; B is dropped.
        a0 = n_acks;
        push_frame(1'b0, 48'h000A_3501_0203, 32'hC0A8_010A, 48'h0, 32'hC0A8_0114);
        push_frame(1'b1, 48'h000A_3501_0203, 32'hC0A8_010A, 48'hAAAA_0000_0001, 32'h0A00_0001);
        push_frame(1'b0, 48'h000A_3501_0203, 32'hC0A8_010A, 48'h0, 32'hC0A8_0114);
        arp_request_req = 1'b1;
        wait_ack(10, lat);
        reply_pulse(48'hAAAA_0000_0001, 32'h0A00_0001);
        reply_pulse(48'hBBBB_0000_0002, 32'h0A00_0002);
        exp_drop = 1;
        wait_ack(60, lat);
        arp_request_req = 1'b0;
        drain(60);
        tick(2);
        chk("prio_drop_cnt", {61'h0, reply_drop_cnt}, 64'(exp_drop));
        chk("prio_acks", 64'(n_acks - a0), 64'd2);

        // Saturation: stall a request, fill the slot, hammer reply_req.
        rdy_mode = 2;
        push_frame(1'b0, 48'h000A_3501_0203, 32'hC0A8_010A, 48'h0, 32'hC0A8_0114);
        push_frame(1'b1, 48'h000A_3501_0203, 32'hC0A8_010A, 48'hCCCC_0000_0003, 32'h0A00_0003);
        arp_request_req = 1'b1;
        wait_ack(10, lat);
        arp_request_req = 1'b0;
        reply_pulse(48'hCCCC_0000_0003, 32'h0A00_0003);
        for (int i = 0; i < 10; i++) begin
            reply_pulse(48'hEEEE_0000_0000 + 48'(i), 32'h0B00_0000);
            exp_drop = (exp_drop == (1 << DW) - 1) ? exp_drop : exp_drop + 1;
        end
        chk("sat_drop_cnt", {61'h0, reply_drop_cnt}, 64'(exp_drop));
        rdy_mode = 0;
        drain(60);
        tick(2);

        // Reset at beat 3 with a reply pending.
        f0 = n_frames;
        push_frame(1'b0, 48'h000A_3501_0203, 32'hC0A8_010A, 48'h0, 32'hC0A8_0114);
        arp_request_req = 1'b1;
        wait_ack(10, lat);
        arp_request_req = 1'b0;
        reply_pulse(48'hDDDD_0000_0004, 32'h0A00_0004);
        tick(2);
        rstn = 1'b0;
        exp_q.delete();
        exp_drop = 0;
        tick(1);
        chk("rst_mid_tvalid", {63'h0, m_axis_tvalid}, 64'h0);
        chk("rst_mid_tlast", {63'h0, m_axis_tlast}, 64'h0);
        rstn = 1'b1;
        tick(20);
        chk("rst_mid_frames", 64'(n_frames - f0), 64'd0);
        chk("rst_mid_drop", {61'h0, reply_drop_cnt}, 64'(exp_drop));
        push_frame(1'b0, 48'h000A_3501_0203, 32'hC0A8_010A, 48'h0, 32'hC0A8_0114);
        arp_request_req = 1'b1;
        wait_ack(10, lat);
        arp_request_req = 1'b0;
        drain(40);
        tick(2);
        chk("rst_after_frames", 64'(n_frames - f0), 64'd1);

        // ARP table closed loop: one request, ack quickly, then quiet.
        f0 = n_frames;
        a0 = n_acks;
        dst_ip_addr = 32'h0A00_0001;
        push_frame(1'b0, 48'h000A_3501_0203, 32'hC0A8_010A, 48'h0, 32'h0A00_0001);
        arp_request_req = 1'b1;
        wait_ack(10, lat);
        chk("loop_ack_latency", 64'(lat), 64'd1);
        arp_request_req = 1'b0;
        drain(40);
        tick(30);
        chk("loop_frames", 64'(n_frames - f0), 64'd1);
        chk("loop_acks", 64'(n_acks - a0), 64'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
